// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master core
package spi_pkg;

    // Wide enough for edge index 2*DATA_W-1 at the largest DATA_W of 32.
    localparam int EDGE_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        HOLD     = 2'd3
    } spi_state_t;

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - tx/rx shift datapath; SPI_MASTER_LSB_FIRST_EN selects LSB-first order
module spi_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              pop,
    input  logic              push,
    input  logic              serial_in,
    output logic              serial_out,
    output logic [DATA_W-1:0] rx_word
);

    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] tx_src;
    logic [DATA_W-1:0] tx_next;
    logic [DATA_W-1:0] rx_next;
    logic              head;

    // A pop in the load cycle drives the first bit of the word being loaded.
    assign tx_src = load ? load_data : tx_q;

`ifdef SPI_MASTER_LSB_FIRST_EN
    assign head    = tx_src[0];
    assign tx_next = tx_src >> 1;
    assign rx_next = {serial_in, rx_word[DATA_W-1:1]};
`else
    assign head    = tx_src[DATA_W-1];
    assign tx_next = tx_src << 1;
    assign rx_next = {rx_word[DATA_W-2:0], serial_in};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q       <= '0;
            serial_out <= 1'b0;
            rx_word    <= '0;
        end else begin
            if (pop) begin
                serial_out <= head;
                tx_q       <= tx_next;
            end else if (load) begin
                serial_out <= 1'b0;
                tx_q       <= load_data;
            end

            if (load) begin
                rx_word <= '0;
            end else if (push) begin
                rx_word <= rx_next;
            end
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// rtl/spi_master_core.sv - SPI master FSM; bit order set by SPI_MASTER_LSB_FIRST_EN in spi_shift_reg
module spi_master_core
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              miso,
    output logic              sclk_o,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data
);

    localparam logic                  IDLE_LVL  = 1'(CPOL);
    localparam logic [EDGE_CNT_W-1:0] LAST_EDGE = EDGE_CNT_W'(2 * DATA_W - 1);

    spi_state_t          state;
    logic [EDGE_CNT_W-1:0] edge_cnt;
    logic                accept;
    logic                xfer_tick;
    logic                leading_edge;
    logic                last_edge;
    logic                sr_pop;
    logic                sr_push;
    logic [DATA_W-1:0]   rx_word;

    assign accept       = (state == IDLE) && start;
    assign xfer_tick    = (state == TRANSFER) && tick;
    assign leading_edge = ~edge_cnt[0];
    assign last_edge    = (edge_cnt == LAST_EDGE);

    // Mode 0 presents bit 0 at accept and advances on trailing edges; mode 1 advances on leading edges.
    always_comb begin
        sr_pop  = 1'b0;
        sr_push = 1'b0;
        if (CPHA == 0) begin
            sr_pop  = accept || (xfer_tick && !leading_edge && !last_edge);
            sr_push = xfer_tick && leading_edge;
        end else begin
            sr_pop  = xfer_tick && leading_edge;
            sr_push = xfer_tick && !leading_edge;
        end
    end

    spi_shift_reg #(
        .DATA_W(DATA_W)
    ) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data (tx_data),
        .pop       (sr_pop),
        .push      (sr_push),
        .serial_in (miso),
        .serial_out(mosi),
        .rx_word   (rx_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            edge_cnt <= '0;
            sclk_o   <= IDLE_LVL;
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        edge_cnt <= '0;
                        cs_n     <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        state <= TRANSFER;
                    end
                end
                TRANSFER: begin
                    if (tick) begin
                        sclk_o   <= ~sclk_o;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (last_edge) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state   <= IDLE;
                        cs_n    <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rx_word;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// tb/tb_spi_master_core.sv - self-checking bench: mode 0 and mode 1 instances, slave model, vector table
module tb_spi_master_core;

    localparam int W = 8;

    typedef struct {
        int           d;
        int           period;
        bit           loop;
        bit           restart;
        logic [W-1:0] tx;
        logic [W-1:0] slv;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_slave;
        int           exp_ticks;
        int           exp_cycles;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] start_v, tick_v, loop_v, miso_v, miso_sl;
    logic [1:0] sclk_v, mosi_v, cs_v, busy_v, done_v;
    logic [1:0][W-1:0] tx_v, rx_v, slave_tx, sl_rx, prev_rx;
    logic [1:0] sl_first;
    logic [1:0] prev_cs = 2'b11;
    logic [1:0] prev_sclk = 2'b00;
    int tick_period[2] = '{4, 4};
    int tick_cnt[2] = '{0, 0};
    int sl_ktx[2] = '{0, 0};
    int sl_krx[2] = '{0, 0};
    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    assign miso_v[0] = loop_v[0] ? mosi_v[0] : miso_sl[0];
    assign miso_v[1] = loop_v[1] ? mosi_v[1] : miso_sl[1];

    spi_master_core #(.DATA_W(W), .CPOL(0), .CPHA(0)) dut0 (
        .clk(clk), .rst(rst), .tick(tick_v[0]), .start(start_v[0]), .tx_data(tx_v[0]),
        .miso(miso_v[0]), .sclk_o(sclk_v[0]), .mosi(mosi_v[0]), .cs_n(cs_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .rx_data(rx_v[0])
    );

    spi_master_core #(.DATA_W(W), .CPOL(0), .CPHA(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick_v[1]), .start(start_v[1]), .tx_data(tx_v[1]),
        .miso(miso_v[1]), .sclk_o(sclk_v[1]), .mosi(mosi_v[1]), .cs_n(cs_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .rx_data(rx_v[1])
    );

    always #5 clk = ~clk;

    // k-th bit on the wire of word w
    function automatic logic bit_at(input logic [W-1:0] w, input int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return w[k];
`else
        return w[W-1-k];
`endif
    endfunction

    function automatic int bit_pos(input int k);
`ifdef SPI_MASTER_LSB_FIRST_EN
        return k;
`else
        return W - 1 - k;
`endif
    endfunction

    function automatic logic [W-1:0] model_rx(input bit loop, input logic [W-1:0] tx, input logic [W-1:0] slv);
        return loop ? tx : slv;
    endfunction

    function automatic vec_t mk(input int d, input int period, input bit loop, input bit restart,
                                input logic [W-1:0] tx, input logic [W-1:0] slv,
                                input logic [W-1:0] exp_rx, input logic [W-1:0] exp_slave, input int exp_cycles);
        vec_t v;
        v.d = d; v.period = period; v.loop = loop; v.restart = restart;
        v.tx = tx; v.slv = slv; v.exp_rx = exp_rx; v.exp_slave = exp_slave;
        v.exp_ticks = 2 * W + 2; v.exp_cycles = exp_cycles;
        return v;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            tick_cnt[d] = (tick_cnt[d] + 1) % tick_period[d];
            tick_v[d] = (tick_cnt[d] == 0);
        end
    end

    // Behavioural SPI slave: instance 0 is mode 0, instance 1 is mode 1, both idle-low clock.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (prev_cs[d] && !cs_v[d]) begin
                sl_krx[d] = 0;
                sl_rx[d] = '0;
                if (d == 0) begin
                    miso_sl[d] = bit_at(slave_tx[d], 0);
                    sl_ktx[d] = 1;
                end else begin
                    miso_sl[d] = 1'b0;
                    sl_ktx[d] = 0;
                end
            end else if (!cs_v[d] && sclk_v[d] != prev_sclk[d]) begin
                logic lead, samp;
                lead = sclk_v[d];
                samp = (d == 0) ? lead : !lead;
                if (samp) begin
                    if (sl_krx[d] == 0) sl_first[d] = mosi_v[d];
                    if (sl_krx[d] < W) sl_rx[d][bit_pos(sl_krx[d])] = mosi_v[d];
                    sl_krx[d]++;
                end else if (sl_ktx[d] < W) begin
                    miso_sl[d] = bit_at(slave_tx[d], sl_ktx[d]);
                    sl_ktx[d]++;
                end
            end
            prev_cs[d] = cs_v[d];
            prev_sclk[d] = sclk_v[d];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_xfer(input vec_t v);
        int d, cyc, ticks, toggles, busy_drop, rx_moved, extra_done, cs_drop;
        bit got, pulsed, t;
        logic ps;
        d = v.d;
        tick_period[d] = v.period;
        loop_v[d] = v.loop;
        slave_tx[d] = v.slv;
        @(negedge clk);
        tx_v[d] = v.tx;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("accept_busy_d%0d", d), busy_v[d], 1);
        check($sformatf("accept_cs_n_d%0d", d), cs_v[d], 0);
        cyc = 1; ticks = 0; toggles = 0; busy_drop = 0; rx_moved = 0;
        got = 0; pulsed = 0; ps = sclk_v[d];
        while (!got && cyc < 400) begin
            @(negedge clk);
            if (v.restart && !pulsed && toggles >= 6) begin
                start_v[d] = 1'b1;
                tx_v[d] = ~v.tx;
                pulsed = 1;
            end else begin
                start_v[d] = 1'b0;
            end
            @(posedge clk);
            t = tick_v[d];
            #1;
            cyc++;
            if (t) ticks++;
            if (sclk_v[d] != ps) toggles++;
            ps = sclk_v[d];
            if (done_v[d]) got = 1;
            else begin
                if (!busy_v[d]) busy_drop++;
                if (rx_v[d] !== prev_rx[d]) rx_moved++;
            end
        end
        check($sformatf("done_seen_d%0d", d), got, 1);
        check($sformatf("ticks_to_done_d%0d", d), ticks, v.exp_ticks);
        if (v.exp_cycles > 0) check($sformatf("clk_of_done_d%0d", d), cyc, v.exp_cycles);
        check($sformatf("rx_data_d%0d", d), rx_v[d], v.exp_rx);
        check($sformatf("sclk_edges_d%0d", d), toggles, 2 * W);
        check($sformatf("busy_at_done_d%0d", d), busy_v[d], 0);
        check($sformatf("cs_n_at_done_d%0d", d), cs_v[d], 1);
        check($sformatf("sclk_idle_d%0d", d), sclk_v[d], 0);
        check($sformatf("busy_gap_d%0d", d), busy_drop, 0);
        check($sformatf("rx_early_change_d%0d", d), rx_moved, 0);
        check($sformatf("slave_saw_d%0d", d), sl_rx[d], v.exp_slave);
        check($sformatf("first_mosi_bit_d%0d", d), sl_first[d], bit_at(v.tx, 0));
        if (v.restart) check("restart_pulsed", pulsed, 1);
        @(negedge clk);
        start_v[d] = 1'b0;
        extra_done = 0; cs_drop = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done_v[d]) extra_done++;
            if (!cs_v[d]) cs_drop++;
        end
        check($sformatf("single_done_d%0d", d), extra_done, 0);
        check($sformatf("no_queued_start_d%0d", d), cs_drop, 0);
        prev_rx[d] = v.exp_rx;
    endtask

    task automatic reset_mid_transfer();
        int toggles, n, dn, csl;
        logic ps;
        tick_period[0] = 2;
        loop_v[0] = 1'b1;
        @(negedge clk);
        tx_v[0] = 8'h3C;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        toggles = 0; n = 0; ps = sclk_v[0];
        while (toggles < 8 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (sclk_v[0] != ps) toggles++;
            ps = sclk_v[0];
        end
        check("rst_reached_edge7", toggles, 8);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_cs_n", cs_v[0], 1);
        check("rst_sclk", sclk_v[0], 0);
        check("rst_busy", busy_v[0], 0);
        check("rst_done", done_v[0], 0);
        check("rst_rx_data", rx_v[0], 0);
        check("rst_mosi", mosi_v[0], 0);
        @(negedge clk);
        rst = 1'b0;
        prev_rx = '0;
        dn = 0; csl = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done_v[0]) dn++;
            if (!cs_v[0]) csl++;
        end
        check("rst_no_done", dn, 0);
        check("rst_stays_idle", csl, 0);
    endtask

    initial begin
        rst = 1'b1;
        start_v = '0;
        loop_v = '0;
        tx_v = '0;
        slave_tx = '0;
        prev_rx = '0;
        sl_rx = '0;
        sl_first = '0;
        miso_sl = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_sclk_d%0d", d), sclk_v[d], 0);
            check($sformatf("reset_cs_n_d%0d", d), cs_v[d], 1);
            check($sformatf("reset_mosi_d%0d", d), mosi_v[d], 0);
            check($sformatf("reset_busy_d%0d", d), busy_v[d], 0);
            check($sformatf("reset_done_d%0d", d), done_v[d], 0);
            check($sformatf("reset_rx_d%0d", d), rx_v[d], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        vecs.push_back(mk(0, 4, 1, 0, 8'hA5, 8'h00, 8'hA5, 8'hA5, -1));
        vecs.push_back(mk(1, 4, 0, 0, 8'hF0, 8'h3C, 8'h3C, 8'hF0, -1));
        vecs.push_back(mk(0, 1, 1, 0, 8'h81, 8'h00, 8'h81, 8'h81, 19));
        vecs.push_back(mk(0, 1, 1, 0, 8'h01, 8'h00, 8'h01, 8'h01, 19));
        vecs.push_back(mk(0, 4, 1, 1, 8'h6B, 8'h00, 8'h6B, 8'h6B, -1));
        vecs.push_back(mk(1, 2, 1, 0, 8'h5A, 8'h00, 8'h5A, 8'h5A, -1));
        vecs.push_back(mk(1, 1, 0, 0, 8'h96, 8'h69, 8'h69, 8'h96, 19));
        vecs.push_back(mk(0, 3, 0, 0, 8'hC3, 8'h1E, 8'h1E, 8'hC3, -1));
        for (int i = 0; i < 12; i++) begin
            int d, p;
            bit lp;
            logic [W-1:0] tx, slv;
            d = int'($urandom_range(0, 1));
            p = int'($urandom_range(1, 5));
            lp = 1'($urandom_range(0, 1));
            tx = W'($urandom);
            slv = W'($urandom);
            vecs.push_back(mk(d, p, lp, 0, tx, slv, model_rx(lp, tx, slv), tx, (p == 1) ? 19 : -1));
        end

        for (int i = 0; i < vecs.size(); i++) begin
            run_xfer(vecs[i]);
        end

        reset_mid_transfer();
        run_xfer(mk(0, 2, 0, 0, 8'h4D, 8'hB2, 8'hB2, 8'h4D, -1));
        run_xfer(mk(1, 3, 1, 0, 8'hE7, 8'h00, 8'hE7, 8'hE7, -1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_core.md
SPI_MASTER_CORE -- requirements
Module: spi_master_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the transfer width in bits (2..32).
REQ-002 SHALL have parameter CPOL, default 0, the idle level of sclk_o.
REQ-003 SHALL have parameter CPHA, default 0: 0 = sample on the leading edge, 1 = sample on the trailing edge.
REQ-004 SHALL have one clock and an asynchronous active-high reset; no other clock/reset ports.
REQ-005 Port clk, input, 1: system clock; all logic rising-edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port tick, input, 1: one-clk pulse from the SPI clock divider; each pulse is one SCLK half-period.
REQ-008 Port start, input, 1: request a transfer; sampled only while busy=0.
REQ-009 Port tx_data, input, DATA_W: word to send; captured on an accepted start.
REQ-010 Port miso, input, 1: serial data in, assumed synchronous to clk.
REQ-011 Port sclk_o, output, 1: SPI clock.
REQ-012 Port mosi, output, 1: serial data out.
REQ-013 Port cs_n, output, 1: chip select, active low.
REQ-014 Port busy, output, 1: high from the clk after an accepted start through the done cycle.
REQ-015 Port done, output, 1: one-clk pulse when a transfer completes.
REQ-016 Port rx_data, output, DATA_W: last received word, stable between done pulses.

Function
REQ-017 SHALL implement the FSM IDLE -> SETUP -> TRANSFER -> HOLD -> IDLE; all outputs are registered.
REQ-018 IDLE: start=1 loads the tx shift register, clears the edge counter and moves to SETUP next clk, with cs_n=0 and busy=1 at that edge.
REQ-019 SETUP: for CPHA=0, mosi carries the first data bit; on tick, move to TRANSFER.
REQ-020 TRANSFER: each tick toggles sclk_o and increments a 6-bit edge counter; even-indexed edges are leading, odd-indexed edges are trailing.
REQ-021 CPHA=0: sample miso on leading edges; shift mosi on trailing edges, except the last one.
REQ-022 CPHA=1: shift mosi on leading edges (first leading edge drives bit 0 of the sequence); sample miso on trailing edges.
REQ-023 After edge 2*DATA_W-1, move to HOLD with sclk_o at CPOL.
REQ-024 HOLD: on tick, go to IDLE; in the same edge drive cs_n=1, busy=0, done=1 and load rx_data.
REQ-025 done SHALL be high for exactly one clk per transfer.
REQ-026 Transfer length SHALL be exactly 2*DATA_W+2 ticks from SETUP entry to done.
REQ-027 start while busy=1 SHALL be ignored, with no queuing.
REQ-028 tick in the same clk as an accepted start SHALL be ignored; SETUP waits for the next tick.
REQ-029 tick held high continuously SHALL be legal, giving an SCLK of clk/2.
REQ-030 Default bit order SHALL be MSB first for both mosi and rx assembly.
REQ-031 rx_data SHALL change only on the done edge.

Reset
REQ-032 rst SHALL immediately force: state=IDLE, sclk_o=CPOL, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, counters=0.
REQ-033 rst asserted mid-transfer SHALL abort with no done pulse; the first start after release behaves as from power-up.

Configuration
REQ-034 Macro SPI_MASTER_LSB_FIRST_EN, when defined, SHALL make both mosi and rx assembly LSB first; timing is unchanged.
REQ-035 Without SPI_MASTER_LSB_FIRST_EN, bit order SHALL be MSB first only, with no LSB logic synthesized.

Structure
REQ-036 Package spi_pkg SHALL hold the FSM state enum (IDLE, SETUP, TRANSFER, HOLD) and the edge-counter width constant.
REQ-037 A sub-module spi_shift_reg (parallel load, serial in/out, direction from the macro) SHALL hold the datapath; the FSM stays in spi_master_core.

Verification
REQ-038 Loopback (miso=mosi), mode 0, DATA_W=8, tick every 4 clk, tx 0xA5 -> rx_data=0xA5, done once, 18 ticks after SETUP entry.
REQ-039 Mode 1 (CPHA=1), miso driven by a slave model sending 0x3C, tx 0xF0 -> slave sees 0xF0, rx_data=0x3C, sclk_o idles 0.
REQ-040 start pulsed again at edge 5 of a transfer -> ignored, exactly one done, busy low only after done.
REQ-041 rst pulsed at edge 7 -> cs_n=1, sclk_o=CPOL, busy=0 on the same clk, no done, rx_data=0.
REQ-042 tick tied to 1, tx 0x81 in loopback -> rx 0x81, done at clk 19 after start is accepted.
REQ-043 With SPI_MASTER_LSB_FIRST_EN defined, tx 0x01 -> first mosi bit 1, loopback rx 0x01.
